// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive path: FSM encoding, parity modes,
// line levels and a counter-width helper.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Bits needed to hold max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT-1 down to 0, flags terminal count, reloads itself.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int unsigned CW = width_for(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load || cnt_q == '0) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, data (selectable order), optional parity, 1-2 stops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_pi,
    output logic                  tx_so,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned IDX_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH - 1 : STOP_BITS - 1;
    localparam int unsigned IW      = width_for(IDX_MAX);
    localparam logic        PAR_SEL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  par_q, par_d;
    logic                  so_q, so_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  load;
    logic                  tick;
    logic                  next_bit;
    logic [DATA_WIDTH-1:0] shift_nx;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(load),
        .tick(tick)
    );

    // Bit leaves from one end of the shift register; the rest moves towards that end.
    assign next_bit = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
    assign shift_nx = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        so_d    = so_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    shift_d = tx_pi;
                    par_d   = (^tx_pi) ^ PAR_SEL;
                    state_d = ST_START;
                    so_d    = LINE_START;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    so_d    = next_bit;
                    shift_d = shift_nx;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (idx_q == IW'(DATA_WIDTH - 1)) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            so_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            so_d    = LINE_STOP;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        so_d    = next_bit;
                        shift_d = shift_nx;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    so_d    = LINE_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        so_d    = LINE_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                so_d    = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            so_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_so   = so_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: five transmitter configurations, per-cycle line levels from a queue.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [5];
    logic        start [5];
    logic [15:0] pi    [5];
    logic        so    [5];
    logic        busy  [5];
    logic        done  [5];

    int n_checks = 0;
    int n_errors = 0;

    int cw   [5] = '{8, 8, 8, 8, 5};
    int cpb  [5] = '{4, 4, 4, 4, 1};
    int pen  [5] = '{0, 1, 1, 0, 1};
    int podd [5] = '{0, 0, 1, 0, 0};
    int stp  [5] = '{1, 1, 1, 2, 1};
    int msb  [5] = '{1, 1, 1, 0, 1};

    logic exp_q[$];

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(1), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst[0]), .tx_start(start[0]), .tx_pi(pi[0][7:0]),
        .tx_so(so[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst[1]), .tx_start(start[1]), .tx_pi(pi[1][7:0]),
        .tx_so(so[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1),
                    .STOP_BITS(1), .MSB_FIRST(1)) u2 (
        .clk(clk), .rst(rst[2]), .tx_start(start[2]), .tx_pi(pi[2][7:0]),
        .tx_so(so[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0),
                    .STOP_BITS(2), .MSB_FIRST(0)) u3 (
        .clk(clk), .rst(rst[3]), .tx_start(start[3]), .tx_pi(pi[3][7:0]),
        .tx_so(so[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0),
                    .STOP_BITS(1), .MSB_FIRST(1)) u4 (
        .clk(clk), .rst(rst[4]), .tx_start(start[4]), .tx_pi(pi[4][4:0]),
        .tx_so(so[4]), .tx_busy(busy[4]), .tx_done(done[4]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for every cycle of one frame.
    function automatic void push_frame(input int k, input logic [15:0] d);
        logic p;
        logic b;
        p = podd[k][0];
        for (int c = 0; c < cpb[k]; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < cw[k]; i++) begin
            b = (msb[k] != 0) ? d[cw[k] - 1 - i] : d[i];
            p = p ^ d[i];
            for (int c = 0; c < cpb[k]; c++) exp_q.push_back(b);
        end
        if (pen[k] != 0)
            for (int c = 0; c < cpb[k]; c++) exp_q.push_back(p);
        for (int c = 0; c < stp[k] * cpb[k]; c++) exp_q.push_back(1'b1);
    endfunction

    task automatic run_frame(input int k, input logic [15:0] d, input bit hold, input bit pulse);
        int   cyc;
        logic e;
        start[k] = 1'b1;
        pi[k]    = d;
        push_frame(k, d);
        @(posedge clk); #1;
        if (!hold) start[k] = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq($sformatf("u%0d d%0h so c%0d", k, d, cyc), so[k], e);
            check_eq($sformatf("u%0d d%0h busy c%0d", k, d, cyc), busy[k], 1);
            check_eq($sformatf("u%0d d%0h done c%0d", k, d, cyc), done[k], 0);
            if (pulse && cyc == 10) begin
                start[k] = 1'b1;
                pi[k]    = 16'h00FF;
            end
            if (pulse && cyc == 11) start[k] = 1'b0;
            cyc++;
            @(posedge clk); #1;
        end
        check_eq($sformatf("u%0d d%0h end so", k, d), so[k], 1);
        check_eq($sformatf("u%0d d%0h end busy", k, d), busy[k], 0);
        check_eq($sformatf("u%0d d%0h end done", k, d), done[k], 1);
    endtask

    task automatic abort_test();
        start[0] = 1'b1;
        pi[0]    = 16'h00A5;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (17) begin
            @(posedge clk); #1;
        end
        // Now inside data bit 3 of 8'hA5 (MSB first), which is 0.
        check_eq("abort pre so", so[0], 0);
        check_eq("abort pre busy", busy[0], 1);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("abort so", so[0], 1);
        check_eq("abort busy", busy[0], 0);
        check_eq("abort done", done[0], 0);
        rst[0] = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("abort quiet done c%0d", c), done[0], 0);
            check_eq($sformatf("abort quiet so c%0d", c), so[0], 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) begin
            rst[k]   = 1'b1;
            start[k] = 1'b0;
            pi[k]    = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("u%0d reset so", k), so[k], 1);
            check_eq($sformatf("u%0d reset busy", k), busy[k], 0);
            check_eq($sformatf("u%0d reset done", k), done[k], 0);
            rst[k] = 1'b0;
        end
        @(posedge clk); #1;

        run_frame(0, 16'h00A5, 1'b0, 1'b0);
        run_frame(1, 16'h00A5, 1'b0, 1'b0);
        run_frame(2, 16'h00A5, 1'b0, 1'b0);
        run_frame(3, 16'h0001, 1'b0, 1'b0);
        run_frame(3, 16'h00C3, 1'b0, 1'b0);
        run_frame(4, 16'h001F, 1'b0, 1'b0);
        run_frame(4, 16'h000A, 1'b0, 1'b0);
        run_frame(1, 16'h0037, 1'b0, 1'b0);

        // Mid-frame request with different data must be ignored.
        run_frame(0, 16'h00A5, 1'b0, 1'b1);

        // Held request: frames separated by exactly one idle cycle.
        run_frame(0, 16'h00A5, 1'b1, 1'b0);
        run_frame(0, 16'h003C, 1'b1, 1'b0);
        run_frame(0, 16'h005A, 1'b0, 1'b0);
        run_frame(4, 16'h0011, 1'b1, 1'b0);
        run_frame(4, 16'h0004, 1'b0, 1'b0);

        abort_test();
        run_frame(0, 16'h00A5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
